// File: rtl/eth_phy_10g_pkg.sv
// Shared 10G PHY definitions used by the TX gearbox and the RX aligner.
//   - Block geometry: 66-bit frame = 2-bit sync header + 64-bit payload.
//   - Sync header codes, idle and error payloads inserted by the TX gearbox.
//   - Gearbox period: 32 blocks are packed into 33 SERDES words.
package eth_phy_10g_pkg;

    localparam int FRAME_WIDTH    = 66;
    localparam int DATA_WIDTH     = 64;
    localparam int HDR_WIDTH      = 2;
    localparam int CNT_WIDTH      = 16;
    localparam int SEQ_WIDTH      = 6;
    localparam int GEARBOX_PERIOD = 33;

    localparam logic [HDR_WIDTH-1:0]  SYNC_DATA = 2'b01;
    localparam logic [HDR_WIDTH-1:0]  SYNC_CTRL = 2'b10;
    localparam logic [DATA_WIDTH-1:0] IDLE_DATA = 64'h0000_0000_0000_001E;
    localparam logic [DATA_WIDTH-1:0] ERR_DATA  = 64'h1E1E_1E1E_1E1E_1E1E;

    // What the TX gearbox places on the line for a given input slot.
    typedef enum logic [1:0] {
        BLK_PASS = 2'd0,
        BLK_IDLE = 2'd1,
        BLK_ERR  = 2'd2
    } blk_kind_e;

    // Only 01 and 10 are legal sync headers; 00 and 11 never appear on the line.
    function automatic logic hdr_is_legal(input logic [HDR_WIDTH-1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_phy_10g_tx_blk_sel.sv
// Combinational block selection for the TX gearbox.
//   valid   : input block present
//   hdr     : input sync header
//   data    : input payload
//   frame   : {hdr, data} to be packed (input, IDLE or ERR block)
//   bad_hdr : input block present with an illegal header
module eth_phy_10g_tx_blk_sel
    import eth_phy_10g_pkg::*;
(
    input  logic                   valid,
    input  logic [HDR_WIDTH-1:0]   hdr,
    input  logic [DATA_WIDTH-1:0]  data,
    output logic [FRAME_WIDTH-1:0] frame,
    output logic                   bad_hdr
);

    blk_kind_e kind;

    always_comb begin
        kind = BLK_PASS;
        if (!valid) begin
            kind = BLK_IDLE;
        end else if (!hdr_is_legal(hdr)) begin
            kind = BLK_ERR;
        end
    end

    always_comb begin
        frame   = {hdr, data};
        bad_hdr = 1'b0;
        case (kind)
            BLK_IDLE: frame = {SYNC_CTRL, IDLE_DATA};
            BLK_ERR: begin
                frame   = {SYNC_CTRL, ERR_DATA};
                bad_hdr = 1'b1;
            end
            default: frame = {hdr, data};
        endcase
    end

endmodule

// File: rtl/eth_phy_10g_tx_gearbox.sv
// 10G Ethernet TX 64b/66b gearbox.
// Packs one 66-bit block per ready cycle into a continuous 64-bit SERDES word
// stream (MSB first on the line). Every 33rd cycle upstream is paused and the
// 64 accumulated residual bits are emitted as a whole word.
//   clk           : clock, rising edge
//   i_rst_n       : asynchronous active-low reset
//   i_tx_hdr      : sync header (01 data, 10 control)
//   i_tx_data     : block payload
//   i_tx_valid    : block present this cycle
//   o_tx_ready    : a presented block is consumed at the coming edge
//   o_serdes_tx   : SERDES word
//   o_bad_hdr_cnt : saturating count of illegal headers consumed
module eth_phy_10g_tx_gearbox
    import eth_phy_10g_pkg::*;
(
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic [HDR_WIDTH-1:0]  i_tx_hdr,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_serdes_tx,
    output logic [CNT_WIDTH-1:0]  o_bad_hdr_cnt
);

    localparam logic [SEQ_WIDTH-1:0] LAST_SEQ = SEQ_WIDTH'(GEARBOX_PERIOD - 1);

    logic [SEQ_WIDTH-1:0]   seq_reg, seq_next;
    logic [DATA_WIDTH-1:0]  res_reg, res_next;      // residual bits, left-justified
    logic [DATA_WIDTH-1:0]  serdes_reg, serdes_next;
    logic                   ready_reg, ready_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;

    logic [FRAME_WIDTH-1:0] frame;
    logic                   bad_hdr;
    logic [SEQ_WIDTH:0]     shift;                  // residual length r = 2*seq
    logic [2*DATA_WIDTH-1:0] wide;                  // W = {R[63 -: r], frame}, left-justified

    eth_phy_10g_tx_blk_sel u_blk_sel (
        .valid   (i_tx_valid),
        .hdr     (i_tx_hdr),
        .data    (i_tx_data),
        .frame   (frame),
        .bad_hdr (bad_hdr)
    );

    // Residual bits below position 63-r are always zero, so OR-ing the frame in
    // right behind them builds W directly. W is at most 62+66 = 128 bits: the
    // upper 64 go out, the lower 64 hold the new residual (r+2 bits, rest zero).
    assign shift = {seq_reg, 1'b0};
    assign wide  = {res_reg, {DATA_WIDTH{1'b0}}}
                 | ({frame, {(2*DATA_WIDTH-FRAME_WIDTH){1'b0}}} >> shift);

    always_comb begin
        seq_next    = seq_reg;
        res_next    = res_reg;
        serdes_next = serdes_reg;
        cnt_next    = cnt_reg;
        if (seq_reg == LAST_SEQ) begin
            // Residual is exactly 64 bits: flush it as a full word.
            serdes_next = res_reg;
            res_next    = '0;
            seq_next    = '0;
        end else if (ready_reg) begin
            serdes_next = wide[2*DATA_WIDTH-1:DATA_WIDTH];
            res_next    = wide[DATA_WIDTH-1:0];
            seq_next    = seq_reg + SEQ_WIDTH'(1);
            if (bad_hdr && (cnt_reg != '1)) begin
                cnt_next = cnt_reg + CNT_WIDTH'(1);
            end
        end
        // The first cycle after reset has ready low with seq 0: nothing is
        // consumed, only ready is raised.
    end

    assign ready_next = (seq_next != LAST_SEQ);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            seq_reg    <= '0;
            res_reg    <= '0;
            serdes_reg <= '0;
            ready_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            seq_reg    <= seq_next;
            res_reg    <= res_next;
            serdes_reg <= serdes_next;
            ready_reg  <= ready_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign o_tx_ready    = ready_reg;
    assign o_serdes_tx   = serdes_reg;
    assign o_bad_hdr_cnt = cnt_reg;

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
// Directed testbench for eth_phy_10g_tx_gearbox. Output words are collected
// MSB first into a bit stream and cut back into 66-bit blocks by a reference
// 64->66 deserializer model.
module tb_eth_phy_10g_tx_gearbox;

    logic        clk;
    logic        i_rst_n;
    logic [1:0]  i_tx_hdr;
    logic [63:0] i_tx_data;
    logic        i_tx_valid;
    logic        o_tx_ready;
    logic [63:0] o_serdes_tx;
    logic [15:0] o_bad_hdr_cnt;

    int checks   = 0;
    int failures = 0;

    bit          bits[$];
    logic [1:0]  rec_hdr[$];
    logic [63:0] rec_data[$];

    eth_phy_10g_tx_gearbox dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_tx_hdr      (i_tx_hdr),
        .i_tx_data     (i_tx_data),
        .i_tx_valid    (i_tx_valid),
        .o_tx_ready    (o_tx_ready),
        .o_serdes_tx   (o_serdes_tx),
        .o_bad_hdr_cnt (o_bad_hdr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word();
        for (int i = 63; i >= 0; i--) bits.push_back(o_serdes_tx[i]);
    endtask

    task automatic decode_blocks();
        logic [65:0] blk;
        rec_hdr.delete();
        rec_data.delete();
        while (bits.size() >= 66) begin
            for (int i = 65; i >= 0; i--) blk[i] = bits.pop_front();
            rec_hdr.push_back(blk[65:64]);
            rec_data.push_back(blk[63:0]);
        end
    endtask

    // Hold reset for a few edges, release on a falling edge so the next rising
    // edge is the first one with reset high (edge 0).
    task automatic do_reset();
        i_rst_n    = 1'b0;
        i_tx_valid = 1'b0;
        i_tx_hdr   = 2'b00;
        i_tx_data  = 64'h0;
        bits.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n    = 1'b0;
        i_tx_valid = 1'b1;
        i_tx_hdr   = 2'b01;
        i_tx_data  = 64'hDEAD_BEEF_0000_0001;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_serdes_tx !== 64'h0) begin
            failures++;
            $display("FAIL reset_serdes got=%h exp=%h", o_serdes_tx, 64'h0);
        end
        checks++;
        if (o_tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0", o_tx_ready);
        end
        checks++;
        if (o_bad_hdr_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_cnt got=%h exp=0000", o_bad_hdr_cnt);
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        step();  // edge 0: ready rises, nothing consumed yet
        checks++;
        if (o_tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_ready got=%b exp=1", o_tx_ready);
        end
        checks++;
        if (o_serdes_tx !== 64'h0) begin
            failures++;
            $display("FAIL release_serdes got=%h exp=%h", o_serdes_tx, 64'h0);
        end
        $display("test_reset done");
    endtask

    task automatic test_continuous();
        logic [63:0] idx;
        logic        rdy;
        logic        exp_rdy;
        do_reset();
        idx = 64'd0;
        rdy = 1'b0;
        for (int c = 0; c <= 330; c++) begin
            i_tx_valid = 1'b1;
            i_tx_hdr   = 2'b01;
            i_tx_data  = idx;
            step();
            if (rdy) idx++;
            if (c >= 1) push_word();
            exp_rdy = ((c + 1) % 33) != 0;
            checks++;
            if (o_tx_ready !== exp_rdy) begin
                failures++;
                $display("FAIL cont_ready cycle=%0d got=%b exp=%b", c, o_tx_ready, exp_rdy);
            end
            rdy = o_tx_ready;
        end
        checks++;
        if (idx !== 64'd320) begin
            failures++;
            $display("FAIL cont_consumed got=%0d exp=320", idx);
        end
        decode_blocks();
        checks++;
        if (rec_hdr.size() != 320) begin
            failures++;
            $display("FAIL cont_nblocks got=%0d exp=320", rec_hdr.size());
        end
        for (int k = 0; k < rec_hdr.size(); k++) begin
            checks++;
            if (rec_hdr[k] !== 2'b01 || rec_data[k] !== 64'(k)) begin
                failures++;
                $display("FAIL cont_block k=%0d got=%b_%h exp=01_%h", k, rec_hdr[k], rec_data[k], 64'(k));
            end
        end
        $display("test_continuous done: %0d blocks recovered", rec_hdr.size());
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c <= 66; c++) begin
            i_tx_valid = 1'b0;
            i_tx_hdr   = 2'b01;
            i_tx_data  = 64'hFFFF_FFFF_FFFF_FFFF;
            step();
            if (c >= 1) push_word();
            if (c == 1) begin
                checks++;
                if (o_serdes_tx !== 64'h8000_0000_0000_0007) begin
                    failures++;
                    $display("FAIL idle_first_word got=%h exp=%h", o_serdes_tx, 64'h8000_0000_0000_0007);
                end
            end
        end
        decode_blocks();
        checks++;
        if (rec_hdr.size() != 64) begin
            failures++;
            $display("FAIL idle_nblocks got=%0d exp=64", rec_hdr.size());
        end
        for (int k = 0; k < rec_hdr.size(); k++) begin
            checks++;
            if (rec_hdr[k] !== 2'b10 || rec_data[k] !== 64'h0000_0000_0000_001E) begin
                failures++;
                $display("FAIL idle_block k=%0d got=%b_%h exp=10_000000000000001e", k, rec_hdr[k], rec_data[k]);
            end
        end
        $display("test_idle done");
    endtask

    task automatic test_bad_hdr();
        logic [1:0]  in_hdr  [4];
        logic [63:0] in_data [4];
        logic [1:0]  ex_hdr  [4];
        logic [63:0] ex_data [4];
        logic [15:0] exp_cnt;
        logic        rdy;
        int          j;
        in_hdr[0] = 2'b01; in_data[0] = 64'h1111_1111_1111_1111;
        in_hdr[1] = 2'b00; in_data[1] = 64'h2222_2222_2222_2222;
        in_hdr[2] = 2'b11; in_data[2] = 64'h3333_3333_3333_3333;
        in_hdr[3] = 2'b10; in_data[3] = 64'h4444_4444_4444_4444;
        ex_hdr[0] = 2'b01; ex_data[0] = 64'h1111_1111_1111_1111;
        ex_hdr[1] = 2'b10; ex_data[1] = 64'h1E1E_1E1E_1E1E_1E1E;
        ex_hdr[2] = 2'b10; ex_data[2] = 64'h1E1E_1E1E_1E1E_1E1E;
        ex_hdr[3] = 2'b10; ex_data[3] = 64'h4444_4444_4444_4444;
        do_reset();
        j = 0;
        rdy = 1'b0;
        exp_cnt = 16'd0;
        for (int c = 0; c <= 33; c++) begin
            if (j < 4) begin
                i_tx_valid = 1'b1;
                i_tx_hdr   = in_hdr[j];
                i_tx_data  = in_data[j];
            end else begin
                i_tx_valid = 1'b0;
            end
            step();
            if (rdy && j < 4) begin
                if (in_hdr[j] == 2'b00 || in_hdr[j] == 2'b11) exp_cnt++;
                j++;
            end
            if (c >= 1) push_word();
            if (c >= 1 && c <= 5) begin
                checks++;
                if (o_bad_hdr_cnt !== exp_cnt) begin
                    failures++;
                    $display("FAIL bad_cnt cycle=%0d got=%0d exp=%0d", c, o_bad_hdr_cnt, exp_cnt);
                end
            end
            rdy = o_tx_ready;
        end
        checks++;
        if (o_bad_hdr_cnt !== 16'd2) begin
            failures++;
            $display("FAIL bad_cnt_final got=%0d exp=2", o_bad_hdr_cnt);
        end
        decode_blocks();
        checks++;
        if (rec_hdr.size() != 32) begin
            failures++;
            $display("FAIL bad_nblocks got=%0d exp=32", rec_hdr.size());
        end
        for (int k = 0; k < rec_hdr.size(); k++) begin
            logic [1:0]  eh;
            logic [63:0] ed;
            eh = (k < 4) ? ex_hdr[k] : 2'b10;
            ed = (k < 4) ? ex_data[k] : 64'h0000_0000_0000_001E;
            checks++;
            if (rec_hdr[k] !== eh || rec_data[k] !== ed) begin
                failures++;
                $display("FAIL bad_block k=%0d got=%b_%h exp=%b_%h", k, rec_hdr[k], rec_data[k], eh, ed);
            end
        end
        $display("test_bad_hdr done");
    endtask

    task automatic test_saturation();
        int   consumed;
        int   guard;
        logic rdy;
        do_reset();
        consumed = 0;
        guard = 0;
        rdy = 1'b0;
        i_tx_valid = 1'b1;
        i_tx_hdr   = 2'b00;
        i_tx_data  = 64'h0BAD_0BAD_0BAD_0BAD;
        while (consumed < 65534 && guard < 70000) begin
            step();
            guard++;
            if (rdy) consumed++;
            rdy = o_tx_ready;
        end
        checks++;
        if (o_bad_hdr_cnt !== 16'hFFFE) begin
            failures++;
            $display("FAIL sat_preload got=%h exp=fffe consumed=%0d", o_bad_hdr_cnt, consumed);
        end
        i_tx_hdr = 2'b11;
        while (consumed < 65537 && guard < 70000) begin
            step();
            guard++;
            if (rdy) consumed++;
            rdy = o_tx_ready;
        end
        checks++;
        if (o_bad_hdr_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_hold got=%h exp=ffff consumed=%0d", o_bad_hdr_cnt, consumed);
        end
        $display("test_saturation done: %0d bad blocks", consumed);
    endtask

    task automatic test_async_reset();
        logic [63:0] idx;
        logic        rdy;
        logic        exp_rdy;
        do_reset();
        idx = 64'd0;
        rdy = 1'b0;
        // Edge 0 raises ready, edges 1..17 consume 17 blocks: seq is now 17.
        for (int c = 0; c <= 17; c++) begin
            i_tx_valid = 1'b1;
            i_tx_hdr   = 2'b01;
            i_tx_data  = 64'hC0DE_0000_0000_0000 | idx;
            step();
            if (rdy) idx++;
            rdy = o_tx_ready;
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_serdes_tx !== 64'h0) begin
            failures++;
            $display("FAIL arst_serdes got=%h exp=%h", o_serdes_tx, 64'h0);
        end
        checks++;
        if (o_tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL arst_ready got=%b exp=0", o_tx_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        bits.delete();
        idx = 64'd0;
        rdy = 1'b0;
        for (int c = 0; c <= 33; c++) begin
            i_tx_valid = 1'b1;
            i_tx_hdr   = 2'b01;
            i_tx_data  = 64'hC0DE_0000_0000_0000 | idx;
            step();
            if (rdy) idx++;
            if (c >= 1) push_word();
            exp_rdy = ((c + 1) % 33) != 0;
            checks++;
            if (o_tx_ready !== exp_rdy) begin
                failures++;
                $display("FAIL arst_ready_pattern cycle=%0d got=%b exp=%b", c, o_tx_ready, exp_rdy);
            end
            rdy = o_tx_ready;
        end
        decode_blocks();
        checks++;
        if (rec_hdr.size() != 32) begin
            failures++;
            $display("FAIL arst_nblocks got=%0d exp=32", rec_hdr.size());
        end
        for (int k = 0; k < rec_hdr.size(); k++) begin
            checks++;
            if (rec_hdr[k] !== 2'b01 || rec_data[k] !== (64'hC0DE_0000_0000_0000 | 64'(k))) begin
                failures++;
                $display("FAIL arst_block k=%0d got=%b_%h exp=01_%h", k, rec_hdr[k], rec_data[k],
                         64'hC0DE_0000_0000_0000 | 64'(k));
            end
        end
        $display("test_async_reset done");
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_tx_valid = 1'b0;
        i_tx_hdr   = 2'b00;
        i_tx_data  = 64'h0;
        test_reset();
        test_continuous();
        test_idle();
        test_bad_hdr();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
